hqm_aw_incdec_cnt: RTL and testbench
====================================

// Module: hqm_AW_incdec_cnt
// PURPOSE
//  - Registered up/down occupancy/credit counter that drives the a/inc_dec inputs of an hqm_AW_incdec
//    instance and captures its sum output as the next count.
//  - Adds request arbitration, saturation at 0/MAX_VAL, load, status flags, and error reporting.
//  - Used by FIFO-occupancy and credit-tracking logic in AW-based pipelines.
// PARAMETERS
//  WIDTH    4         counter width in bits (>0)
//  MAX_VAL  2**WIDTH-1  saturation ceiling (1..2**WIDTH-1)
//  RST_VAL  0         count value after reset (0..MAX_VAL)
// PORTS
//  clk        in   1      clock
//  rst        in   1      synchronous active-high reset
//  inc        in   1      increment request, this cycle
//  dec        in   1      decrement request, this cycle
//  load_v     in   1      load request
//  load_val   in   WIDTH  value to load
//  thresh     in   WIDTH  quasi-static threshold for at_thresh
//  err_clr    in   1      clears err_sticky
//  cnt        out  WIDTH  registered count
//  empty      out  1      registered, cnt==0
//  full       out  1      registered, cnt==MAX_VAL
//  at_thresh  out  1      combinational, cnt>=thresh
//  ovf_err    out  1      1-cycle pulse on overflow attempt
//  unf_err    out  1      1-cycle pulse on underflow attempt
//  err_sticky out  2      {ovf,unf} sticky flags
// BEHAVIOUR
//  - Reset (clk edge with rst=1): cnt=RST_VAL; empty/full from RST_VAL; ovf_err=unf_err=0; err_sticky=0.
//  - Latency: request in cycle N -> cnt/empty/full updated at the cycle N+1 edge. No stall, no handshake.
//  - Priority: load_v > inc/dec. When load_v=1, inc/dec are dropped silently.
//  - Load: load_val<=MAX_VAL -> cnt=load_val. load_val>MAX_VAL -> cnt=MAX_VAL and ovf_err pulses.
//  - inc&dec together (no load): cnt holds; no error, even when cnt is 0 or MAX_VAL.
//  - inc only: cnt<MAX_VAL -> cnt+1 via the incdec (inc_dec=0). cnt==MAX_VAL -> hold and ovf_err pulses.
//  - dec only: cnt>0 -> cnt-1 via the incdec (inc_dec=1). cnt==0 -> hold and unf_err pulses.
//  - The raw incdec wrap (all-ones+1, 0-1) is never committed; saturation logic gates it.
//  - empty/full are computed from the next-state value, so they always match cnt in the same cycle.
//  - err_sticky[1]/[0] set on ovf_err/unf_err and clear on err_clr.
//    Same-cycle set and err_clr -> set wins.
//  - Reset asserted mid-operation overrides all requests that cycle.
//  - Initial-block asserts check WIDTH>0, MAX_VAL range, and RST_VAL<=MAX_VAL.
//    They honour +AW_CONTINUE_ON_ERROR and are guarded by INTEL_SVA_OFF.
// STRUCTURE
//  - One hqm_AW_incdec #(.WIDTH(WIDTH)) instance: a=cnt, inc_dec=dec&~inc, sum -> next-state mux.
//  - Next-state mux (reset/load/hold/sum) plus flop stage. Flags derived from the next-state value.
//  - hqm_AW_pkg: add typedef struct packed {logic ovf; logic unf;} aw_cnt_err_t for err_sticky.
//    No other sub-modules.
// TESTING (WIDTH=4, MAX_VAL=10, RST_VAL=0, thresh=8)
//  - Reset, then 10 inc -> cnt 0..10, full=1 at 10, at_thresh=1 from cnt=8, empty=0 after the 1st inc.
//  - inc at cnt=10 -> cnt stays 10, ovf_err pulses 1 cycle, err_sticky=2'b10; err_clr -> 2'b00.
//  - dec at cnt=0 -> cnt 0, unf_err pulse; inc&dec at cnt=0 and at cnt=10 -> hold, no error.
//  - load_v with load_val=5 and inc=1 -> cnt=5. load_val=15 -> cnt=10, ovf_err pulse.
//  - cnt=7, assert rst with inc=1 -> cnt=0, empty=1, all errors 0.
//  - Random inc/dec/load for 10k cycles vs reference model: cnt always in 0..10, flags consistent.

Source files
------------

// File: rtl/hqm_aw_incdec_cnt_pkg.sv
// Shared types for the saturating up/down counter: sticky error record and request decode.
package hqm_aw_incdec_cnt_pkg;

    typedef struct packed {
        logic ovf;
        logic unf;
    } aw_cnt_err_t;

    typedef enum logic [1:0] {
        REQ_HOLD = 2'd0,
        REQ_LOAD = 2'd1,
        REQ_INC  = 2'd2,
        REQ_DEC  = 2'd3
    } cnt_req_e;

    // Load outranks inc/dec; inc and dec together cancel into a hold.
    function automatic cnt_req_e decode_req(input logic load_v, input logic inc, input logic dec);
        cnt_req_e req;
        req = REQ_HOLD;
        if (load_v) begin
            req = REQ_LOAD;
        end else if (inc && !dec) begin
            req = REQ_INC;
        end else if (dec && !inc) begin
            req = REQ_DEC;
        end
        return req;
    endfunction

endpackage

// File: rtl/hqm_aw_incdec_cnt_incdec.sv
// Plain wrapping incrementer/decrementer: sum = a+1 when inc_dec=0, a-1 when inc_dec=1.
module hqm_aw_incdec_cnt_incdec #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic             inc_dec_i,
    output logic [WIDTH-1:0] sum_o
);

    assign sum_o = inc_dec_i ? (a_i - WIDTH'(1)) : (a_i + WIDTH'(1));

endmodule

// File: rtl/hqm_aw_incdec_cnt.sv
// Registered occupancy/credit counter with load, saturation at 0/MAX_VAL, status flags and error reporting.
module hqm_aw_incdec_cnt
    import hqm_aw_incdec_cnt_pkg::*;
#(
    parameter int WIDTH   = 4,
    parameter int MAX_VAL = (1 << WIDTH) - 1,
    parameter int RST_VAL = 0
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             inc_i,
    input  logic             dec_i,
    input  logic             load_v_i,
    input  logic [WIDTH-1:0] load_val_i,
    input  logic [WIDTH-1:0] thresh_i,
    input  logic             err_clr_i,
    output logic [WIDTH-1:0] cnt_o,
    output logic             empty_o,
    output logic             full_o,
    output logic             at_thresh_o,
    output logic             ovf_err_o,
    output logic             unf_err_o,
    output logic [1:0]       err_sticky_o
);

    localparam logic [WIDTH-1:0] MAX_CNT = WIDTH'(MAX_VAL);
    localparam logic [WIDTH-1:0] RST_CNT = WIDTH'(RST_VAL);

`ifndef INTEL_SVA_OFF
    if (WIDTH < 1) begin : g_chk_width
        $error("hqm_aw_incdec_cnt: WIDTH must be > 0");
    end
    if ((MAX_VAL < 1) || (MAX_VAL > (1 << WIDTH) - 1)) begin : g_chk_max
        $error("hqm_aw_incdec_cnt: MAX_VAL out of range");
    end
    if ((RST_VAL < 0) || (RST_VAL > MAX_VAL)) begin : g_chk_rst
        $error("hqm_aw_incdec_cnt: RST_VAL exceeds MAX_VAL");
    end
`endif

    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic             empty_q, empty_d;
    logic             full_q, full_d;
    logic             ovf_q, ovf_d;
    logic             unf_q, unf_d;
    aw_cnt_err_t      sticky_q, sticky_d;
    logic [WIDTH-1:0] sum;
    cnt_req_e         req;

    hqm_aw_incdec_cnt_incdec #(
        .WIDTH (WIDTH)
    ) u_incdec (
        .a_i       (cnt_q),
        .inc_dec_i (dec_i & ~inc_i),
        .sum_o     (sum)
    );

    assign req = decode_req(load_v_i, inc_i, dec_i);

    // The raw incdec result is only taken when it cannot wrap.
    always_comb begin
        cnt_d = cnt_q;
        ovf_d = 1'b0;
        unf_d = 1'b0;
        unique case (req)
            REQ_LOAD: begin
                if (load_val_i > MAX_CNT) begin
                    cnt_d = MAX_CNT;
                    ovf_d = 1'b1;
                end else begin
                    cnt_d = load_val_i;
                end
            end
            REQ_INC: begin
                if (cnt_q == MAX_CNT) begin
                    ovf_d = 1'b1;
                end else begin
                    cnt_d = sum;
                end
            end
            REQ_DEC: begin
                if (cnt_q == '0) begin
                    unf_d = 1'b1;
                end else begin
                    cnt_d = sum;
                end
            end
            default: ;
        endcase
        empty_d      = (cnt_d == '0);
        full_d       = (cnt_d == MAX_CNT);
        sticky_d.ovf = ovf_d | (sticky_q.ovf & ~err_clr_i);
        sticky_d.unf = unf_d | (sticky_q.unf & ~err_clr_i);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q    <= RST_CNT;
            empty_q  <= (RST_CNT == '0);
            full_q   <= (RST_CNT == MAX_CNT);
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
            sticky_q <= '0;
        end else begin
            cnt_q    <= cnt_d;
            empty_q  <= empty_d;
            full_q   <= full_d;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
            sticky_q <= sticky_d;
        end
    end

    assign cnt_o        = cnt_q;
    assign empty_o      = empty_q;
    assign full_o       = full_q;
    assign at_thresh_o  = (cnt_q >= thresh_i);
    assign ovf_err_o    = ovf_q;
    assign unf_err_o    = unf_q;
    assign err_sticky_o = sticky_q;

endmodule

// File: tb/tb_hqm_aw_incdec_cnt.sv
// Scoreboard bench for hqm_aw_incdec_cnt with WIDTH=4, MAX_VAL=10, RST_VAL=0.
module tb_hqm_aw_incdec_cnt;

    localparam int W    = 4;
    localparam int MAXV = 10;

    logic         clk = 1'b0;
    logic         rst, inc, dec, load_v, err_clr;
    logic [W-1:0] load_val, thresh;
    logic [W-1:0] cnt;
    logic         empty, full, at_thresh, ovf_err, unf_err;
    logic [1:0]   err_sticky;

    typedef struct {
        int unsigned cnt;
        bit          empty;
        bit          full;
        bit          ovf;
        bit          unf;
        int unsigned sticky;
    } exp_t;

    exp_t        sb_q[$];
    int unsigned m_cnt;
    bit          m_st_ovf, m_st_unf;
    int          n_vec  = 0;
    int          n_miss = 0;

    always #5 clk = ~clk;

    hqm_aw_incdec_cnt #(
        .WIDTH   (W),
        .MAX_VAL (MAXV),
        .RST_VAL (0)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .inc_i        (inc),
        .dec_i        (dec),
        .load_v_i     (load_v),
        .load_val_i   (load_val),
        .thresh_i     (thresh),
        .err_clr_i    (err_clr),
        .cnt_o        (cnt),
        .empty_o      (empty),
        .full_o       (full),
        .at_thresh_o  (at_thresh),
        .ovf_err_o    (ovf_err),
        .unf_err_o    (unf_err),
        .err_sticky_o (err_sticky)
    );

    task automatic chk(input string tag, input int unsigned obs, input int unsigned exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Drive one cycle of requests, predict the result, then compare after the edge.
    task automatic step(input bit r, input bit i, input bit d, input bit ld,
                        input int unsigned lv, input bit clr);
        exp_t e;
        bit   p_ovf, p_unf;
        @(negedge clk);
        rst = r; inc = i; dec = d; load_v = ld; load_val = W'(lv); err_clr = clr;
        p_ovf = 0;
        p_unf = 0;
        if (r) begin
            m_cnt = 0; m_st_ovf = 0; m_st_unf = 0;
        end else begin
            if (ld) begin
                if (lv > MAXV) begin m_cnt = MAXV; p_ovf = 1; end
                else m_cnt = lv;
            end else if (i && !d) begin
                if (m_cnt == MAXV) p_ovf = 1; else m_cnt = m_cnt + 1;
            end else if (d && !i) begin
                if (m_cnt == 0) p_unf = 1; else m_cnt = m_cnt - 1;
            end
            m_st_ovf = p_ovf || (m_st_ovf && !clr);
            m_st_unf = p_unf || (m_st_unf && !clr);
        end
        e.cnt = m_cnt; e.empty = (m_cnt == 0); e.full = (m_cnt == MAXV);
        e.ovf = p_ovf; e.unf = p_unf; e.sticky = {30'd0, m_st_ovf, m_st_unf};
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        e = sb_q.pop_front();
        chk("cnt", cnt, e.cnt);
        chk("empty", empty, e.empty);
        chk("full", full, e.full);
        chk("at_thresh", at_thresh, (e.cnt >= thresh) ? 1 : 0);
        chk("ovf_err", ovf_err, e.ovf);
        chk("unf_err", unf_err, e.unf);
        chk("err_sticky", err_sticky, e.sticky);
        $display("step r=%0b i=%0b d=%0b ld=%0b lv=%0d clr=%0b -> cnt=%0d e=%0b f=%0b ovf=%0b unf=%0b st=%b",
                 r, i, d, ld, lv, clr, cnt, empty, full, ovf_err, unf_err, err_sticky);
    endtask

    initial begin
        rst = 1; inc = 0; dec = 0; load_v = 0; load_val = '0; err_clr = 0; thresh = W'(8);
        m_cnt = 0; m_st_ovf = 0; m_st_unf = 0;

        step(1, 0, 0, 0, 0, 0);
        chk("rst_cnt", cnt, 0);
        chk("rst_empty", empty, 1);

        for (int k = 1; k <= 10; k++) begin
            step(0, 1, 0, 0, 0, 0);
            chk("ramp_cnt", cnt, k);
        end
        chk("ramp_full", full, 1);
        chk("ramp_thresh", at_thresh, 1);

        step(0, 1, 0, 0, 0, 0);
        chk("sat_cnt", cnt, 10);
        chk("sat_ovf", ovf_err, 1);
        chk("sat_sticky", err_sticky, 2);
        step(0, 0, 0, 0, 0, 0);
        chk("ovf_pulse_end", ovf_err, 0);
        step(0, 0, 0, 0, 0, 1);
        chk("clr_sticky", err_sticky, 0);

        step(0, 1, 1, 0, 0, 0);
        chk("both_full_hold", cnt, 10);
        step(0, 0, 0, 1, 0, 0);
        step(0, 0, 1, 0, 0, 0);
        chk("unf_cnt", cnt, 0);
        chk("unf_pulse", unf_err, 1);
        step(0, 1, 1, 0, 0, 1);
        chk("both_empty_err", {30'd0, ovf_err, unf_err}, 0);
        step(0, 0, 1, 0, 0, 1);
        chk("set_beats_clr", err_sticky, 1);

        step(0, 1, 0, 1, 5, 0);
        chk("load5", cnt, 5);
        step(0, 0, 0, 1, 15, 0);
        chk("load15_cnt", cnt, 10);
        chk("load15_ovf", ovf_err, 1);

        step(0, 0, 0, 1, 7, 1);
        step(1, 1, 0, 0, 0, 0);
        chk("midrst_cnt", cnt, 0);
        chk("midrst_empty", empty, 1);
        chk("midrst_sticky", err_sticky, 0);

        for (int k = 0; k < 10000; k++) begin
            int unsigned sel;
            sel = $urandom_range(0, 99);
            if (k == 5000) thresh = W'(3);
            step((sel == 0), $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
                 (sel < 6), $urandom_range(0, 15), (sel > 90));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
